// File: rtl/cpu6502_pkg.sv
// Shared 6502 core definitions: flag-update opcodes, P bit positions and
// the packed flag storage used by the status register.
package cpu6502_pkg;

    localparam logic [3:0] P_HOLD     = 4'd0;
    localparam logic [3:0] P_NZ_ALU   = 4'd1;
    localparam logic [3:0] P_NZC_ALU  = 4'd2;
    localparam logic [3:0] P_NVZC_ALU = 4'd3;
    localparam logic [3:0] P_BIT      = 4'd4;
    localparam logic [3:0] P_NZ_DB    = 4'd5;
    localparam logic [3:0] P_LOAD_DB  = 4'd6;
    localparam logic [3:0] P_CLC      = 4'd7;
    localparam logic [3:0] P_SEC      = 4'd8;
    localparam logic [3:0] P_CLI      = 4'd9;
    localparam logic [3:0] P_SEI      = 4'd10;
    localparam logic [3:0] P_CLV      = 4'd11;
    localparam logic [3:0] P_CLD      = 4'd12;
    localparam logic [3:0] P_SED      = 4'd13;
    localparam logic [3:0] P_INT      = 4'd14;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] P_RESET = 8'h34;

    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0, i: 1'b1, z: 1'b0, c: 1'b0};

    // Bits 5 and 4 are never stored; the caller supplies the B bit value.
    function automatic logic [7:0] pack_p(input flags_t f, input logic b);
        pack_p = {f.n, f.v, 1'b1, b, f.d, f.i, f.z, f.c};
    endfunction

endpackage

// File: rtl/sync_edge_6502.sv
// CE-gated multi-flop synchroniser with a one-flop history for falling-edge detection.
module sync_edge_6502 #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nRESET,
    input  logic CE,
    input  logic din,
    output logic level,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Flops reset high so an idle (released) request line never looks like an edge.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else if (CE) begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign fall  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/status_int_6502.sv
// 6502 processor status register plus IRQ/NMI synchronisation and pending logic.
module status_int_6502
    import cpu6502_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       CE,
    input  logic [3:0] P_OP,
    input  logic       ALU_COUT,
    input  logic       ALU_VOUT,
    input  logic       ALU_NOUT,
    input  logic       ALU_ZOUT,
    input  logic [7:0] DB_IN,
    input  logic       BRK,
    input  logic       IRQ_n,
    input  logic       NMI_n,
    input  logic       NMI_ACK,
    output logic [7:0] P,
    output logic [7:0] P_PUSH,
    output logic       CARRY_IN,
    output logic       D_flag,
    output logic       IRQ_PEND,
    output logic       NMI_PEND
);

    flags_t flags_q, flags_d;
    logic   irq_level, irq_fall_unused;
    logic   nmi_level_unused, nmi_fall;
    logic   nmi_latch_q;

    always_comb begin
        flags_d = flags_q;
        case (P_OP)
            P_NZ_ALU: begin
                flags_d.n = ALU_NOUT;
                flags_d.z = ALU_ZOUT;
            end
            P_NZC_ALU: begin
                flags_d.n = ALU_NOUT;
                flags_d.z = ALU_ZOUT;
                flags_d.c = ALU_COUT;
            end
            P_NVZC_ALU: begin
                flags_d.n = ALU_NOUT;
                flags_d.v = ALU_VOUT;
                flags_d.z = ALU_ZOUT;
                flags_d.c = ALU_COUT;
            end
            P_BIT: begin
                flags_d.n = DB_IN[7];
                flags_d.v = DB_IN[6];
                flags_d.z = ALU_ZOUT;
            end
            P_NZ_DB: begin
                flags_d.n = DB_IN[7];
                flags_d.z = (DB_IN == 8'h00);
            end
            P_LOAD_DB: begin
                flags_d.n = DB_IN[P_N];
                flags_d.v = DB_IN[P_V];
                flags_d.d = DB_IN[P_D];
                flags_d.i = DB_IN[P_I];
                flags_d.z = DB_IN[P_Z];
                flags_d.c = DB_IN[P_C];
            end
            P_CLC: flags_d.c = 1'b0;
            P_SEC: flags_d.c = 1'b1;
            P_CLI: flags_d.i = 1'b0;
            P_SEI: flags_d.i = 1'b1;
            P_CLV: flags_d.v = 1'b0;
            P_CLD: flags_d.d = 1'b0;
            P_SED: flags_d.d = 1'b1;
            // NMOS parts leave D alone on interrupt entry.
            P_INT: flags_d.i = 1'b1;
            default: flags_d = flags_q;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET)
            flags_q <= FLAGS_RESET;
        else if (CE)
            flags_q <= flags_d;
    end

    sync_edge_6502 #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk    (clk),
        .nRESET (nRESET),
        .CE     (CE),
        .din    (IRQ_n),
        .level  (irq_level),
        .fall   (irq_fall_unused)
    );

    sync_edge_6502 #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk    (clk),
        .nRESET (nRESET),
        .CE     (CE),
        .din    (NMI_n),
        .level  (nmi_level_unused),
        .fall   (nmi_fall)
    );

    // A fresh edge wins over a coincident ACK so a back-to-back NMI is not dropped.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET)
            nmi_latch_q <= 1'b0;
        else if (CE) begin
            if (nmi_fall)
                nmi_latch_q <= 1'b1;
            else if (NMI_ACK)
                nmi_latch_q <= 1'b0;
        end
    end

    assign P        = pack_p(flags_q, 1'b1);
    assign P_PUSH   = pack_p(flags_q, BRK);
    assign CARRY_IN = flags_q.c;
    assign D_flag   = flags_q.d;
    assign IRQ_PEND = ~irq_level & ~flags_q.i;
    assign NMI_PEND = nmi_latch_q;

endmodule

// File: tb/tb_status_int_6502.sv
// Directed self-checking bench for the 6502 status register / interrupt front end.
module tb_status_int_6502;
    import cpu6502_pkg::*;

    logic       clk = 1'b0;
    logic       nRESET;
    logic       CE;
    logic [3:0] P_OP;
    logic       ALU_COUT, ALU_VOUT, ALU_NOUT, ALU_ZOUT;
    logic [7:0] DB_IN;
    logic       BRK;
    logic       IRQ_n, NMI_n, NMI_ACK;
    logic [7:0] P, P_PUSH;
    logic       CARRY_IN, D_flag, IRQ_PEND, NMI_PEND;

    int n_chk  = 0;
    int n_fail = 0;

    status_int_6502 #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .nRESET   (nRESET),
        .CE       (CE),
        .P_OP     (P_OP),
        .ALU_COUT (ALU_COUT),
        .ALU_VOUT (ALU_VOUT),
        .ALU_NOUT (ALU_NOUT),
        .ALU_ZOUT (ALU_ZOUT),
        .DB_IN    (DB_IN),
        .BRK      (BRK),
        .IRQ_n    (IRQ_n),
        .NMI_n    (NMI_n),
        .NMI_ACK  (NMI_ACK),
        .P        (P),
        .P_PUSH   (P_PUSH),
        .CARRY_IN (CARRY_IN),
        .D_flag   (D_flag),
        .IRQ_PEND (IRQ_PEND),
        .NMI_PEND (NMI_PEND)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] code);
        P_OP = code;
        cyc();
        P_OP = P_HOLD;
    endtask

    initial begin
        nRESET = 1'b0; CE = 1'b1; P_OP = P_HOLD;
        ALU_COUT = 0; ALU_VOUT = 0; ALU_NOUT = 0; ALU_ZOUT = 0;
        DB_IN = 8'h00; BRK = 1'b1; IRQ_n = 1'b1; NMI_n = 1'b1; NMI_ACK = 1'b0;
        #12;
        chk("reset_P", P, 8'h34);
        chk("reset_PUSH_brk1", P_PUSH, 8'h34);
        BRK = 1'b0; #1;
        chk("reset_PUSH_brk0", P_PUSH, 8'h24);
        chk("reset_irq_pend", {7'b0, IRQ_PEND}, 8'h00);
        chk("reset_nmi_pend", {7'b0, NMI_PEND}, 8'h00);
        chk("reset_carry", {7'b0, CARRY_IN}, 8'h00);
        cyc();
        nRESET = 1'b1;
        cyc();
        chk("post_release_P", P, 8'h34);

        // ADC-style update
        ALU_COUT = 1; ALU_VOUT = 1; ALU_NOUT = 1; ALU_ZOUT = 0;
        op(P_NVZC_ALU);
        chk("nvzc_P", P, 8'hF5);
        chk("nvzc_carry", {7'b0, CARRY_IN}, 8'h01);

        // CE low must hold everything
        ALU_COUT = 0; ALU_VOUT = 0; ALU_NOUT = 0; ALU_ZOUT = 1;
        CE = 1'b0;
        op(P_NVZC_ALU);
        chk("ce0_hold_P", P, 8'hF5);
        CE = 1'b1;

        op(4'd15);
        chk("reserved_hold_P", P, 8'hF5);

        DB_IN = 8'h0B;
        op(P_LOAD_DB);
        chk("load_db_P", P, 8'h3B);
        chk("load_db_dflag", {7'b0, D_flag}, 8'h01);

        DB_IN = 8'hC0; ALU_ZOUT = 1;
        op(P_BIT);
        chk("bit_P", P, 8'hFB);

        DB_IN = 8'h00;
        op(P_NZ_DB);
        chk("nz_db_zero_P", P, 8'h7B);
        DB_IN = 8'h80;
        op(P_NZ_DB);
        chk("nz_db_neg_P", P, 8'hF9);

        // IRQ masked, then unmasked, then released
        op(P_SEI);
        chk("sei_P", P, 8'hFD);
        IRQ_n = 1'b0;
        cyc(); cyc(); cyc();
        chk("irq_masked", {7'b0, IRQ_PEND}, 8'h00);
        op(P_CLI);
        chk("cli_P", P, 8'hF9);
        chk("irq_unmasked", {7'b0, IRQ_PEND}, 8'h01);
        IRQ_n = 1'b1;
        cyc();
        chk("irq_release_1", {7'b0, IRQ_PEND}, 8'h01);
        cyc();
        chk("irq_release_2", {7'b0, IRQ_PEND}, 8'h00);

        // NMI edge, latency SYNC_STAGES+1
        NMI_n = 1'b0;
        cyc(); cyc();
        chk("nmi_lat_2", {7'b0, NMI_PEND}, 8'h00);
        cyc();
        chk("nmi_lat_3", {7'b0, NMI_PEND}, 8'h01);
        chk("nmi_indep_of_irq", {7'b0, IRQ_PEND}, 8'h00);
        NMI_ACK = 1'b1;
        cyc();
        NMI_ACK = 1'b0;
        chk("nmi_ack", {7'b0, NMI_PEND}, 8'h00);
        cyc(); cyc(); cyc();
        chk("nmi_no_retrigger", {7'b0, NMI_PEND}, 8'h00);

        // New edge coinciding with ACK survives
        NMI_n = 1'b1;
        cyc(); cyc(); cyc();
        NMI_n = 1'b0;
        cyc(); cyc();
        NMI_ACK = 1'b1;
        cyc();
        NMI_ACK = 1'b0;
        chk("nmi_edge_on_ack", {7'b0, NMI_PEND}, 8'h01);
        cyc();
        chk("nmi_edge_on_ack_hold", {7'b0, NMI_PEND}, 8'h01);

        DB_IN = 8'hFF;
        op(P_LOAD_DB);
        chk("load_ff_P", P, 8'hFF);

        // Asynchronous reset between clock edges
        P_OP = P_CLI;
        @(posedge clk);
        #3;
        nRESET = 1'b0;
        #1;
        chk("async_reset_P", P, 8'h34);
        chk("async_reset_nmi", {7'b0, NMI_PEND}, 8'h00);
        cyc();
        chk("reset_overrides_op", P, 8'h34);
        P_OP = P_HOLD;
        nRESET = 1'b1;
        cyc();
        chk("after_rerelease_P", P, 8'h34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
